svm_pixel_mac: RTL and testbench

//  Downstream consumer of the pixel-RAM fetch stage: takes the pixel stream (one XLEN_PIXEL

---
 rtl/svm_pixel_mac.sv | 144 ++++++++++++++
 tb/tb_svm_pixel_mac.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_pixel_mac.sv
// Linear SVM decision value: score = sum(pixel[k]*weight[k]) + bias, held until result_ack.
// Define SVM_MAC_SATURATE_EN to clamp every accumulate and raise a sticky sat_flag; default wraps.
module svm_pixel_mac #(
   parameter int XLEN_PIXEL    = 8,
   parameter int XLEN_WEIGHT   = 8,
   parameter int NUM_OF_PIXELS = 4,
   parameter int ACC_WIDTH     = 24,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   pixel_valid,
   input  logic [XLEN_PIXEL-1:0]  pixel_in,
   output logic                   pixel_ready,
   output logic [ADDR_WIDTH-1:0]  weight_addr,
   input  logic [XLEN_WEIGHT-1:0] weight_in,
   input  logic [ACC_WIDTH-1:0]   bias_in,
   output logic                   busy,
   output logic                   result_valid,
   input  logic                   result_ack,
   output logic [ACC_WIDTH-1:0]   score,
   output logic                   class_out,
   output logic                   sat_flag
);

   localparam int PROD_W = XLEN_PIXEL + XLEN_WEIGHT + 1;
`ifdef SVM_MAC_SATURATE_EN
   // One guard bit above the wider of accumulator and product keeps the raw sum exact.
   localparam int EXT_W = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
`else
   localparam int EXT_W = ACC_WIDTH;
`endif
   localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(NUM_OF_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

   state_t                      state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic [ADDR_WIDTH-1:0]       cnt;
   logic signed [EXT_W-1:0]     pixel_s;
   logic signed [EXT_W-1:0]     weight_s;
   logic signed [EXT_W-1:0]     addend;
   logic signed [EXT_W-1:0]     sum;
   logic                        beat;

   assign beat        = pixel_valid && pixel_ready;
   assign weight_addr = cnt;

   // Shared adder: the product during ACCUM, the bias during BIAS.
   always_comb begin
      pixel_s  = EXT_W'($signed({1'b0, pixel_in}));
      weight_s = EXT_W'($signed(weight_in));
      addend   = (state == BIAS) ? EXT_W'($signed(bias_in)) : pixel_s * weight_s;
      sum      = EXT_W'(acc) + addend;
   end

`ifdef SVM_MAC_SATURATE_EN
   logic [EXT_W-ACC_WIDTH:0] sum_top;
   logic                     clamp;

   // The sum fits when every bit from the accumulator MSB upward agrees.
   always_comb begin
      sum_top = sum[EXT_W-1:ACC_WIDTH-1];
      clamp   = !((&sum_top) || !(|sum_top));
      if (!clamp)
         acc_next = sum[ACC_WIDTH-1:0];
      else if (sum[EXT_W-1])
         acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
         acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   end
`else
   assign acc_next = sum;
   assign sat_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         acc          <= '0;
         cnt          <= '0;
         score        <= '0;
         class_out    <= 1'b0;
         result_valid <= 1'b0;
         pixel_ready  <= 1'b0;
         busy         <= 1'b0;
`ifdef SVM_MAC_SATURATE_EN
         sat_flag     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= ACCUM;
                  acc         <= '0;
                  cnt         <= '0;
                  pixel_ready <= 1'b1;
                  busy        <= 1'b1;
`ifdef SVM_MAC_SATURATE_EN
                  sat_flag    <= 1'b0;
`endif
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc <= acc_next;
`ifdef SVM_MAC_SATURATE_EN
                  sat_flag <= sat_flag | clamp;
`endif
                  if (cnt == LAST_BEAT) begin
                     cnt         <= '0;
                     state       <= BIAS;
                     pixel_ready <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            BIAS: begin
               // Score is captured here so it is already stable on entry to DONE.
               acc          <= acc_next;
               score        <= acc_next;
               class_out    <= ~acc_next[ACC_WIDTH-1];
               result_valid <= 1'b1;
               state        <= DONE;
`ifdef SVM_MAC_SATURATE_EN
               sat_flag     <= sat_flag | clamp;
`endif
            end
            DONE: begin
               if (result_ack) begin
                  state        <= IDLE;
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_svm_pixel_mac.sv
// Self-checking bench for svm_pixel_mac: a 24-bit and a 16-bit accumulator instance share stimulus.
module tb_svm_pixel_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, pixel_valid, result_ack;
   logic [7:0]  pixel_in;
   logic signed [7:0] rom [0:3];

   logic [9:0]  addr24, addr16;
   logic [7:0]  w24, w16;
   logic [23:0] bias24, score24;
   logic [15:0] bias16, score16;
   logic        ready24, busy24, rv24, cls24, sat24;
   logic        ready16, busy16, rv16, cls16, sat16;

   assign w24 = (addr24 < 10'd4) ? rom[addr24[1:0]] : 8'd0;
   assign w16 = (addr16 < 10'd4) ? rom[addr16[1:0]] : 8'd0;

   svm_pixel_mac #(.ACC_WIDTH(24)) dut24 (
      .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .pixel_ready(ready24), .weight_addr(addr24), .weight_in(w24), .bias_in(bias24),
      .busy(busy24), .result_valid(rv24), .result_ack(result_ack), .score(score24),
      .class_out(cls24), .sat_flag(sat24)
   );

   svm_pixel_mac #(.ACC_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .pixel_ready(ready16), .weight_addr(addr16), .weight_in(w16), .bias_in(bias16),
      .busy(busy16), .result_valid(rv16), .result_ack(result_ack), .score(score16),
      .class_out(cls16), .sat_flag(sat16)
   );

   int passed = 0;
   int total  = 0;

   int vpix [4];
   int vw   [4];
   int vbias;

   typedef struct {
      logic [0:3][7:0] pix;
      logic [0:3][7:0] w;
      int              bias;
      int              gap;
      longint          exp_score;
      bit              exp_class;
      bit              has16;
      longint          exp16;
      bit              exp_sat16;
   } vec_t;

   vec_t tbl [7];

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      total++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Plain integer arithmetic over the whole vector, folded into accw bits after each term.
   function automatic longint modelScore(input int accw, output bit sat);
      longint acc, maxv, minv, span, term;
      acc  = 0;
      sat  = 1'b0;
      maxv = (longint'(1) <<< (accw - 1)) - 1;
      minv = -maxv - 1;
      span = longint'(1) <<< accw;
      for (int k = 0; k < 5; k++) begin
         term = (k < 4) ? longint'(vpix[k]) * longint'(vw[k]) : longint'(vbias);
         acc += term;
`ifdef SVM_MAC_SATURATE_EN
         if (acc > maxv) begin acc = maxv; sat = 1'b1; end
         else if (acc < minv) begin acc = minv; sat = 1'b1; end
`else
         while (acc > maxv) acc -= span;
         while (acc < minv) acc += span;
`endif
      end
      return acc;
   endfunction

   // Drives one vector up to the cycle where result_valid must have just risen.
   task automatic applyStimulus(input int gap, input string tag);
      for (int k = 0; k < 4; k++) rom[k] = 8'(vw[k]);
      bias24 = 24'(vbias);
      bias16 = 16'(vbias);
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom);
      @(posedge clk); #1;
      checkOutput({tag, " idle_ignores_pixel"}, longint'(busy24), 0);
      pixel_valid = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput({tag, " ready"}, longint'(ready24), 1);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            pixel_valid = 1'b0;
            start       = 1'($urandom_range(1));
            result_ack  = 1'($urandom_range(1));
            pixel_in    = 8'($urandom);
            @(posedge clk); #1;
         end
         start      = 1'b0;
         result_ack = 1'b0;
         checkOutput($sformatf("%s addr%0d", tag, k), longint'(addr24), longint'(k));
         pixel_valid = 1'b1;
         pixel_in    = 8'(vpix[k]);
         @(posedge clk); #1;
      end
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom);
      checkOutput({tag, " bias_not_ready"}, longint'(ready24), 0);
      checkOutput({tag, " rv_early"}, longint'(rv24), 0);
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      checkOutput({tag, " rv_latency"}, longint'(rv24), 1);
   endtask

   task automatic checkResult(input string tag, input longint exp24, input bit expCls,
                              input longint exp16, input bit expSat16);
      bit s24, s16;
      longint dummy;
      dummy = modelScore(24, s24);
      dummy = modelScore(16, s16);
      checkOutput({tag, " score24"}, longint'($signed(score24)), exp24);
      checkOutput({tag, " class24"}, longint'(cls24), longint'(expCls));
      checkOutput({tag, " sat24"}, longint'(sat24), longint'(s24));
      checkOutput({tag, " score16"}, longint'($signed(score16)), exp16);
      checkOutput({tag, " sat16"}, longint'(sat16), longint'(expSat16));
      checkOutput({tag, " class16"}, longint'(cls16), (exp16 >= 0) ? 1 : 0);
   endtask

   task automatic ackResult(input string tag, input longint exp24);
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
      checkOutput({tag, " ack_rv"}, longint'(rv24), 0);
      checkOutput({tag, " ack_busy"}, longint'(busy24), 0);
      checkOutput({tag, " ack_hold"}, longint'($signed(score24)), exp24);
   endtask

   task automatic loadRow(input vec_t r);
      for (int k = 0; k < 4; k++) begin
         vpix[k] = int'(r.pix[k]);
         vw[k]   = int'($signed(r.w[k]));
      end
      vbias = r.bias;
   endtask

   initial begin
      bit     msat;
      longint m16;

      // pixels, weights, bias, gap, expected 24-bit score/class, optional hand 16-bit result
      tbl[0] = '{{8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 0, 10, 1'b1, 1'b0, 0, 1'b0};
      tbl[1] = '{{8'd255, 8'd255, 8'd255, 8'd255}, {8'h80, 8'h80, 8'h80, 8'h80}, 0, 0, -130560, 1'b0, 1'b0, 0, 1'b0};
      tbl[2] = '{{8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 2, 10, 1'b1, 1'b0, 0, 1'b0};
      tbl[3] = '{{8'd10, 8'd20, 8'd30, 8'd40}, {8'd2, 8'hFF, 8'd3, 8'hFE}, -5, 1, 5, 1'b1, 1'b0, 0, 1'b0};
      tbl[4] = '{{8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, -4, 0, 0, 1'b1, 1'b0, 0, 1'b0};
      tbl[5] = '{{8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, -5, 0, -1, 1'b0, 1'b0, 0, 1'b0};
`ifdef SVM_MAC_SATURATE_EN
      tbl[6] = '{{8'd255, 8'd255, 8'd255, 8'd255}, {8'd127, 8'd127, 8'd127, 8'd127}, 0, 0, 129540, 1'b1, 1'b1, 32767, 1'b1};
`else
      tbl[6] = '{{8'd255, 8'd255, 8'd255, 8'd255}, {8'd127, 8'd127, 8'd127, 8'd127}, 0, 0, 129540, 1'b1, 1'b1, -1532, 1'b0};
`endif

      rst = 1'b1; start = 1'b0; pixel_valid = 1'b0; result_ack = 1'b0; pixel_in = '0;
      bias24 = '0; bias16 = '0;
      for (int k = 0; k < 4; k++) rom[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", longint'(busy24), 0);
      checkOutput("reset ready", longint'(ready24), 0);
      checkOutput("reset rv", longint'(rv24), 0);
      checkOutput("reset addr", longint'(addr24), 0);
      checkOutput("reset score", longint'(score24), 0);
      checkOutput("reset class", longint'(cls24), 0);
      checkOutput("reset sat", longint'(sat24), 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         string tag;
         tag = $sformatf("row%0d", i);
         loadRow(tbl[i]);
         applyStimulus(tbl[i].gap, tag);
         m16 = modelScore(16, msat);
         if (tbl[i].has16) checkResult(tag, tbl[i].exp_score, tbl[i].exp_class, tbl[i].exp16, tbl[i].exp_sat16);
         else checkResult(tag, tbl[i].exp_score, tbl[i].exp_class, m16, msat);
         ackResult(tag, tbl[i].exp_score);
      end

      // Reset after two accepted beats aborts the vector.
      loadRow(tbl[0]);
      for (int k = 0; k < 4; k++) rom[k] = 8'(vw[k]);
      bias24 = '0; bias16 = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         pixel_valid = 1'b1;
         pixel_in    = 8'(vpix[k]);
         @(posedge clk); #1;
      end
      pixel_valid = 1'b0;
      checkOutput("abort addr_before", longint'(addr24), 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort busy", longint'(busy24), 0);
      checkOutput("abort ready", longint'(ready24), 0);
      checkOutput("abort addr", longint'(addr24), 0);
      checkOutput("abort score", longint'(score24), 0);
      checkOutput("abort rv", longint'(rv24), 0);
      @(posedge clk); #1;
      checkOutput("abort stays_idle", longint'(busy24), 0);
      applyStimulus(0, "after_abort");
      checkResult("after_abort", 10, 1'b1, 10, 1'b0);
      ackResult("after_abort", 10);

      // DONE held without ack while start pulses; result must stay put.
      loadRow(tbl[3]);
      applyStimulus(0, "hold");
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         @(posedge clk); #1;
         checkOutput($sformatf("hold rv%0d", c), longint'(rv24), 1);
         checkOutput($sformatf("hold score%0d", c), longint'($signed(score24)), 5);
      end
      start = 1'b0;
      ackResult("hold", 5);
      @(posedge clk); #1;
      checkOutput("hold no_restart", longint'(busy24), 0);

      for (int i = 0; i < 25; i++) begin
         longint m24;
         bit     s24;
         string  tag;
         tag = $sformatf("rand%0d", i);
         for (int k = 0; k < 4; k++) begin
            vpix[k] = int'($urandom_range(255));
            vw[k]   = int'($urandom_range(255)) - 128;
         end
         vbias = int'($urandom_range(60000)) - 30000;
         applyStimulus(int'($urandom_range(2)), tag);
         m24 = modelScore(24, s24);
         m16 = modelScore(16, msat);
         checkResult(tag, m24, (m24 >= 0), m16, msat);
         ackResult(tag, m24);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
